// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, 1 start bit, 1 stop bit, no parity.
//
// Parameters
//   clk_hz     system clock frequency in Hz
//   baud_rate  line bit rate in bits/s (clk_hz / baud_rate must be 4..65535)
//
// Ports
//   clk        single clock, all state updates on its rising edge
//   rst_n      asynchronous active-low reset
//   rx         asynchronous serial line, idle high
//   rx_data    last correctly framed byte, held between frames
//   rx_valid   one-cycle pulse when rx_data is updated
//   rx_busy    high while a frame is being received
//   frame_err  one-cycle pulse when the stop bit samples low
module uart_rx #(
  parameter int unsigned clk_hz    = 50_000_000,
  parameter int unsigned baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int unsigned Cpb  = clk_hz / baud_rate;
  localparam int unsigned Half = Cpb / 2;

  localparam logic [15:0] CpbLast  = 16'(Cpb - 1);
  localparam logic [15:0] HalfLast = 16'(Half - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // Two-flop synchronizer plus one delay flop for falling-edge detection.
  logic rx_meta_q;
  logic rx_s_q;
  logic rx_d_q;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Edge, not level: a line parked low after a break cannot retrigger.
        if (rx_d_q && !rx_s_q) begin
          state_d = StStart;
          cnt_d   = 16'd0;
        end
      end

      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = 16'd0;
          if (!rx_s_q) begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end else begin
            // Start bit gone by mid-bit: treat as a glitch.
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StData: begin
        if (cnt_q == CpbLast) begin
          shift_d[bit_idx_q] = rx_s_q;
          cnt_d              = 16'd0;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StStop: begin
        if (cnt_q == CpbLast) begin
          // Leave at mid stop bit so a following start edge is never missed.
          state_d = StIdle;
          cnt_d   = 16'd0;
          if (rx_s_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = 16'd0;
      end
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CPB = 16, HALF = 8.
// Frames are driven bit by bit; each frame pushes its expected outcome
// (good byte or framing error) into a queue that a monitor pops on every pulse.
module tb_uart_rx;

  localparam int unsigned Cpb = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  uart_rx #(
    .clk_hz   (16),
    .baud_rate(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] kind;  // 2'b01 good byte, 2'b10 framing error
    logic [7:0] data;  // rx_data expected while the pulse is high
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_data;

  int n_cmp;
  int n_mis;
  int cyc;
  int busy_run;
  int last_busy;
  int last_valid_cyc;
  int n_valid;
  int n_ferr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_busy) begin
      busy_run <= busy_run + 1;
    end else if (busy_run != 0) begin
      last_busy <= busy_run;
      busy_run  <= 0;
    end
  end

  // Pulse monitor: every sampled pulse cycle must match the next queued event.
  always @(negedge clk) begin
    if (rst_n && (rx_valid || frame_err)) begin
      logic [1:0] exp_kind;
      logic [7:0] exp_data;
      exp_kind = 2'b00;
      exp_data = model_data;
      if (exp_q.size() != 0) begin
        exp_kind = exp_q[0].kind;
        exp_data = exp_q[0].data;
        void'(exp_q.pop_front());
      end
      check_eq("pulse_kind", {frame_err, rx_valid}, exp_kind);
      check_eq("pulse_data", rx_data, exp_data);
      if (rx_valid) begin
        n_valid        <= n_valid + 1;
        last_valid_cyc <= cyc;
      end
      if (frame_err) n_ferr <= n_ferr + 1;
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    ev_t e;
    if (stop) begin
      e.kind     = 2'b01;
      e.data     = b;
      model_data = b;
    end else begin
      e.kind = 2'b10;
      e.data = model_data;
    end
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic send_idle(input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(1'b1);
  endtask

  // Bounded wait for the receiver to go idle with every expected pulse seen.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rx_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_drain"}, exp_q.size(), 0);
    check_eq({tag, "_busy"}, rx_busy, 1'b0);
  endtask

  initial begin
    int t0;
    int v0;
    int f0;
    int lat;
    logic [7:0] b;
    logic       stop;
    logic       prev_stop;

    n_cmp = 0; n_mis = 0; cyc = 0; busy_run = 0; last_busy = 0;
    last_valid_cyc = 0; n_valid = 0; n_ferr = 0; model_data = 8'h00;
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_data", rx_data, 8'h00);
    check_eq("rst_valid", rx_valid, 1'b0);
    check_eq("rst_ferr", frame_err, 1'b0);
    check_eq("rst_busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Single good frame with latency and busy-duration checks.
    v0 = n_valid;
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    send_idle(2);
    drain("a5");
    check_eq("a5_count", n_valid - v0, 1);
    check_eq("a5_data", rx_data, 8'hA5);
    lat = last_valid_cyc - t0;
    check_eq("a5_latency_ok", (lat >= 154 && lat <= 156), 1'b1);
    check_eq("a5_busy_len_ok", (last_busy >= 151 && last_busy <= 153), 1'b1);

    // Back-to-back frames, no idle gap.
    v0 = n_valid;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_idle(2);
    drain("b2b");
    check_eq("b2b_count", n_valid - v0, 2);
    check_eq("b2b_data", rx_data, 8'hFF);

    // Stop bit forced low, line held low: no retrigger until a fresh edge.
    f0 = n_ferr;
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    repeat (3 * Cpb) @(negedge clk);
    check_eq("ferr_hold_busy", rx_busy, 1'b0);
    send_idle(2);
    drain("ferr");
    check_eq("ferr_count", n_ferr - f0, 1);
    check_eq("ferr_data_kept", rx_data, 8'hFF);

    // Short glitch on idle line.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    drain("glitch");
    check_eq("glitch_busy_len_ok", (last_busy >= 7 && last_busy <= 9), 1'b1);

    // Reset during data bit 3 of 8'h81, then resend.
    rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 3; i++) send_bit(1'(8'h81 >> i));
    rx = 1'b0;
    repeat (Cpb / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("abort_busy", rx_busy, 1'b0);
    check_eq("abort_data", rx_data, 8'h00);
    model_data = 8'h00;
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    send_idle(2);
    check_eq("abort_idle_busy", rx_busy, 1'b0);
    v0 = n_valid;
    send_frame(8'h81, 1'b1);
    send_idle(1);
    drain("resend");
    check_eq("resend_count", n_valid - v0, 1);
    check_eq("resend_data", rx_data, 8'h81);

    // Break: 40 bit times low.
    f0 = n_ferr;
    exp_q.push_back('{kind: 2'b10, data: model_data});
    rx = 1'b0;
    repeat (40 * Cpb) @(negedge clk);
    check_eq("break_busy", rx_busy, 1'b0);
    send_idle(3);
    drain("break");
    check_eq("break_count", n_ferr - f0, 1);
    check_eq("break_data_kept", rx_data, 8'h81);

    // Random frames, occasional bad stop bits, random gaps.
    prev_stop = 1'b1;
    for (int k = 0; k < 24; k++) begin
      int gap;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      // After a low stop bit the line must rise before a new start edge exists.
      gap = prev_stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
      send_idle(gap);
      send_frame(b, stop);
      prev_stop = stop;
    end
    send_idle(2);
    drain("rand");
    check_eq("rand_final_data", rx_data, model_data);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter clk_hz, default 50_000_000, giving the system clock frequency in Hz.
REQ-002 The block SHALL have parameter baud_rate, default 9600, giving the line bit rate in bits/s.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 The block SHALL have port rx_data, output, 8 bits: last correctly framed byte received.
REQ-007 The block SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data is updated.
REQ-008 The block SHALL have port rx_busy, output, 1 bit: high while a frame is being received.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit samples low.

Function
REQ-010 Local constants SHALL be CPB = clk_hz/baud_rate (integer division) and HALF = CPB/2; CPB SHALL be 4..65535, and the baud counter SHALL be 16 bits.
REQ-011 rx SHALL pass through a two-flop synchronizer (rx_s), plus one further delay flop (rx_d); all three reset to 1.
REQ-012 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); there is no parity.
REQ-013 The FSM SHALL have states IDLE, START, DATA, and STOP; rx_busy SHALL be 1 in START, DATA, and STOP, and 0 in IDLE.
REQ-014 IDLE: on falling edge (rx_d==1 and rx_s==0), go to START with baud counter = 0; otherwise stay. A line held low SHALL NOT retrigger.
REQ-015 START: the counter SHALL increment each cycle. At count HALF-1: if rx_s==0, go to DATA with counter = 0 and bit index = 0; if rx_s==1 (glitch), return to IDLE with no output pulse.
REQ-016 DATA: the counter SHALL increment each cycle. At count CPB-1: store rx_s into shift[bit index], set counter to 0, and increment the bit index; after bit index 7 is stored, go to STOP.
REQ-017 STOP: the counter SHALL increment each cycle. At count CPB-1 (mid stop bit), go to IDLE in the same cycle, with:
- rx_s==1: rx_data <= shift register, rx_valid = 1 for exactly one cycle.
- rx_s==0: frame_err = 1 for exactly one cycle; rx_data unchanged; rx_valid stays 0.
REQ-018 rx_valid and frame_err SHALL never be high in the same cycle, and SHALL be 0 in every other cycle.
REQ-019 rx_data SHALL hold its value between valid frames.
REQ-020 Latency: rx_valid SHALL rise HALF + 9*CPB cycles (±1) after the cycle rx_s first reads 0.
REQ-021 Back-to-back frames: a start edge arriving immediately after the stop-bit sample SHALL be accepted without loss.
REQ-022 Any rx activity while rx_busy==1 SHALL affect only sampled values, never state timing.

Reset
REQ-023 When rst_n==0, the block SHALL immediately (asynchronously) force: state = IDLE, counter = 0, bit index = 0, shift = 0, rx_data = 8'h00, rx_valid = 0, frame_err = 0, rx_busy = 0, synchronizer flops = 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no rx_valid or frame_err pulse. After release, the block SHALL wait for a new falling edge.

Verification (clk_hz=16, baud_rate=1, so CPB=16, HALF=8)
REQ-025 The bench SHALL send byte 8'hA5 with a valid stop bit -> exactly one rx_valid pulse, rx_data = 8'hA5, frame_err = 0, rx_busy high for about 152 cycles.
REQ-026 The bench SHALL send 8'h3C then 8'hFF back-to-back with no idle gap -> two rx_valid pulses, with rx_data 8'h3C then 8'hFF.
REQ-027 The bench SHALL send 8'h55 with the stop bit forced to 0 -> frame_err pulses once, rx_valid stays 0, rx_data keeps its previous value, and there is no new frame until rx returns high and falls again.
REQ-028 The bench SHALL drive a 4-cycle low glitch on idle rx -> the FSM returns to IDLE after the START check, with no rx_valid and no frame_err.
REQ-029 The bench SHALL assert rst_n low during data bit 3 of 8'h81, then resend 8'h81 -> no pulse from the aborted frame; the resent frame gives rx_data = 8'h81.
REQ-030 The bench SHALL hold rx low for 40 bit times (break) -> one frame_err pulse, then no further activity until a new falling edge.
